// File: rtl/axi_cmd_pkg.sv
// axi_cmd_pkg: shared types and response codes for the AXI4-Lite command master.
package axi_cmd_pkg;
    localparam int CMD_ADDR_W = 11;
    localparam int CMD_DATA_W = 32;
    localparam int CMD_STRB_W = CMD_DATA_W / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;
    typedef struct packed {
        logic                  rnw;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [CMD_STRB_W-1:0] wstrb;
    } cmd_t;
    typedef struct packed {
        logic                  rnw;
        logic [CMD_DATA_W-1:0] rdata;
        logic [1:0]            resp;
        logic                  timeout;
    } rsp_t;
endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// axi_lite_cmd_master_if: command/response streams plus the AXI4-Lite master channel set.
interface axi_lite_cmd_master_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    logic          cmd_valid, cmd_ready, cmd_rnw;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_rnw, rsp_timeout, busy;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    modport master (
        input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        output cmd_ready, rsp_valid, rsp_rnw, rsp_rdata, rsp_resp, rsp_timeout, busy,
               awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready
    );
    modport slave (
        output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        input  cmd_ready, rsp_valid, rsp_rnw, rsp_rdata, rsp_resp, rsp_timeout, busy,
               awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding AXI4-Lite initiator fed by a valid/ready command stream.
// Optional hung-slave watchdog enabled by defining AXI_CMD_TIMEOUT_EN.
module axi_lite_cmd_master
    import axi_cmd_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 11,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input logic M_AXI_ACLK,
    input logic M_AXI_ARESETN,
    axi_lite_cmd_master_if.master bus
);
    state_t state_q, state_d;
    cmd_t   cmd_q, cmd_d;
    rsp_t   rsp_q, rsp_d;
    logic   cmd_ready_q, cmd_ready_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d;
    logic   awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic   arvalid_q, arvalid_d, rready_q, rready_d;
`ifdef AXI_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_d       = rsp_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_d = '{rnw: bus.cmd_rnw, addr: CMD_ADDR_W'(bus.cmd_addr),
                              wdata: CMD_DATA_W'(bus.cmd_wdata), wstrb: CMD_STRB_W'(bus.cmd_wstrb)};
                    cmd_ready_d = 1'b0;
                    awvalid_d   = !bus.cmd_rnw;
                    wvalid_d    = !bus.cmd_rnw;
                    arvalid_d   = bus.cmd_rnw;
                    state_d     = bus.cmd_rnw ? RD_A : WR;
                end
            end
            WR: begin
                // AW and W complete independently; a dropped VALID marks its channel done
                awvalid_d = awvalid_q && !bus.awready;
                wvalid_d  = wvalid_q && !bus.wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (bus.bvalid) begin
                    rsp_d       = '{rnw: 1'b0, rdata: '0, resp: bus.bresp, timeout: 1'b0};
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_A: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (bus.rvalid) begin
                    rsp_d       = '{rnw: 1'b1, rdata: CMD_DATA_W'(bus.rdata), resp: bus.rresp, timeout: 1'b0};
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI_CMD_TIMEOUT_EN
        cnt_d = (state_q == IDLE) ? '0 : (state_q == RSP) ? cnt_q : cnt_q + 1'b1;
        // Watchdog abandons the AXI transfer outright; it overrides any same-cycle handshake
        if (state_q != IDLE && state_q != RSP && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_d       = '{rnw: cmd_q.rnw, rdata: '0, resp: RESP_DECERR, timeout: 1'b1};
            rsp_valid_d = 1'b1;
            state_d     = RSP;
        end
`endif
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_q       <= '{rnw: 1'b0, rdata: '0, resp: RESP_OKAY, timeout: 1'b0};
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
`ifdef AXI_CMD_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
`ifdef AXI_CMD_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rnw     = rsp_q.rnw;
    assign bus.rsp_rdata   = C_M_AXI_DATA_WIDTH'(rsp_q.rdata);
    assign bus.rsp_resp    = rsp_q.resp;
    assign bus.rsp_timeout = rsp_q.timeout;
    assign bus.awaddr      = C_M_AXI_ADDR_WIDTH'(cmd_q.addr);
    assign bus.araddr      = C_M_AXI_ADDR_WIDTH'(cmd_q.addr);
    assign bus.awprot      = 3'b000;
    assign bus.arprot      = 3'b000;
    assign bus.awvalid     = awvalid_q;
    assign bus.wdata       = C_M_AXI_DATA_WIDTH'(cmd_q.wdata);
    assign bus.wstrb       = (C_M_AXI_DATA_WIDTH / 8)'(cmd_q.wstrb);
    assign bus.wvalid      = wvalid_q;
    assign bus.bready      = bready_q;
    assign bus.arvalid     = arvalid_q;
    assign bus.rready      = rready_q;
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: randomized slave/command stimulus checked against a transaction-level model.
module tb_axi_lite_cmd_master;
`ifdef AXI_CMD_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    axi_lite_cmd_master_if #(.AW(11), .DW(32)) bus ();
    axi_lite_cmd_master #(.C_M_AXI_ADDR_WIDTH(11), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .bus(bus));

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic idle_inputs;
        bus.cmd_valid = 0; bus.cmd_rnw = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
        bus.rsp_ready = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
    endtask

    // One full transaction; the slave side follows the given wait counts and the
    // expected response is derived from the command and what the slave returned.
    task automatic do_txn(input logic rnw, input logic [10:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int aw_w, input int w_w, input int d_w, input logic [31:0] rd,
                          input logic [1:0] rr, input int rsp_w, input logic pend,
                          output int t_rsp, output int t_idle);
        int n, ph, hs_n, guard;
        logic aw_hs, w_hs;
        logic [31:0] exp_rdata;
        exp_rdata = rnw ? rd : 32'h0;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready_wait got=%b exp=1", bus.cmd_ready); end
        bus.cmd_valid = 1; bus.cmd_rnw = rnw; bus.cmd_addr = a; bus.cmd_wdata = wd; bus.cmd_wstrb = ws;
        @(negedge clk);
        if (pend) begin bus.cmd_rnw = !rnw; bus.cmd_addr = ~a; end
        else bus.cmd_valid = 0;
        aw_hs = 0; w_hs = 0; ph = 0; hs_n = 0; t_rsp = -1;
        for (n = 1; n < 100 && ph < 3; n++) begin
            checks++;
            if ({bus.cmd_ready, bus.busy} !== 2'b01) begin failures++; $display("FAIL busy_state n=%0d got=%b exp=01", n, {bus.cmd_ready, bus.busy}); end
            case (ph)
                0: begin
                    if (rnw) begin
                        checks++;
                        if ({bus.arvalid, bus.araddr, bus.awvalid, bus.wvalid, bus.rsp_valid} !== {1'b1, a, 3'b000}) begin
                            failures++; $display("FAIL ar_phase n=%0d got=%h exp=%h", n, {bus.arvalid, bus.araddr, bus.awvalid, bus.wvalid, bus.rsp_valid}, {1'b1, a, 3'b000});
                        end
                        bus.arready = n > aw_w;
                        if (bus.arready) begin ph = 1; hs_n = n; end
                    end else begin
                        checks++;
                        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.rsp_valid} !== {!aw_hs, !w_hs, 2'b00}) begin
                            failures++; $display("FAIL wr_valids n=%0d got=%b exp=%b", n, {bus.awvalid, bus.wvalid, bus.arvalid, bus.rsp_valid}, {!aw_hs, !w_hs, 2'b00});
                        end
                        checks++;
                        if ({bus.awaddr, bus.wdata, bus.wstrb, bus.awprot} !== {a, wd, ws, 3'b000}) begin
                            failures++; $display("FAIL wr_payload n=%0d got=%h exp=%h", n, {bus.awaddr, bus.wdata, bus.wstrb, bus.awprot}, {a, wd, ws, 3'b000});
                        end
                        bus.awready = !aw_hs && n > aw_w;
                        bus.wready  = !w_hs && n > w_w;
                        aw_hs = aw_hs | bus.awready;
                        w_hs  = w_hs | bus.wready;
                        if (aw_hs && w_hs) begin ph = 1; hs_n = n; end
                    end
                end
                1: begin
                    bus.awready = 0; bus.wready = 0; bus.arready = 0;
                    checks++;
                    if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid} !== {3'b000, !rnw, rnw, 1'b0}) begin
                        failures++; $display("FAIL data_phase n=%0d got=%b exp=%b", n, {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid}, {3'b000, !rnw, rnw, 1'b0});
                    end
                    bus.bvalid = !rnw && n > hs_n + d_w;
                    bus.rvalid = rnw && n > hs_n + d_w;
                    bus.bresp = rr; bus.rresp = rr;
                    bus.rdata = bus.rvalid ? rd : $urandom;
                    if (bus.bvalid || bus.rvalid) ph = 2;
                end
                default: begin
                    bus.bvalid = 0; bus.rvalid = 0; bus.rdata = $urandom; bus.rresp = ~rr; bus.bresp = ~rr;
                    if (t_rsp < 0) t_rsp = n;
                    checks++;
                    if ({bus.rsp_valid, bus.rsp_rnw, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, bus.bready, bus.rready} !== {1'b1, rnw, exp_rdata, rr, 3'b000}) begin
                        failures++; $display("FAIL rsp_fields n=%0d got=%h exp=%h", n, {bus.rsp_valid, bus.rsp_rnw, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, bus.bready, bus.rready}, {1'b1, rnw, exp_rdata, rr, 3'b000});
                    end
                    bus.rsp_ready = n >= t_rsp + rsp_w;
                    if (bus.rsp_ready) ph = 3;
                end
            endcase
            @(negedge clk);
        end
        bus.rsp_ready = 0;
        t_idle = n;
        checks++;
        if (ph !== 3 || {bus.cmd_ready, bus.busy, bus.rsp_valid} !== 3'b100) begin
            failures++; $display("FAIL txn_end ph=%0d got=%b exp=100", ph, {bus.cmd_ready, bus.busy, bus.rsp_valid});
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_timeout, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 9'h0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0", {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_timeout, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
        end
        checks++;
        if ({bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, bus.rsp_rdata, bus.rsp_resp, bus.rsp_rnw, bus.awprot, bus.arprot} !== '0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, bus.rsp_rdata, bus.rsp_resp, bus.rsp_rnw});
        end
        rst_n = 1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_release_ready got=%b exp=0", bus.cmd_ready); end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_first_ready got=%b exp=1", bus.cmd_ready); end
    endtask

    task automatic test_write_zero_wait;
        int t_rsp, t_idle;
        do_txn(1'b0, 11'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0, 2'b00, 0, 1'b0, t_rsp, t_idle);
        checks++;
        if (t_rsp !== 3 || t_idle !== 4) begin failures++; $display("FAIL write_latency got=%0d/%0d exp=3/4", t_rsp, t_idle); end
    endtask

    task automatic test_write_w_first;
        int t_rsp, t_idle;
        do_txn(1'b0, 11'h123, 32'hA5A55A5A, 4'h6, 3, 0, 1, 32'h0, 2'b10, 0, 1'b0, t_rsp, t_idle);
        checks++;
        if (t_rsp !== 7) begin failures++; $display("FAIL w_first_latency got=%0d exp=7", t_rsp); end
        checks++;
        if (bus.bready !== 1'b0) begin failures++; $display("FAIL extra_bready got=%b exp=0", bus.bready); end
    endtask

    task automatic test_read_wait;
        int t_rsp, t_idle;
        do_txn(1'b1, 11'h004, 32'h0, 4'h0, 0, 0, 5, 32'h12345678, 2'b10, 0, 1'b0, t_rsp, t_idle);
        checks++;
        if (t_rsp !== 8) begin failures++; $display("FAIL read_latency got=%0d exp=8", t_rsp); end
    endtask

    task automatic test_backpressure;
        int t_rsp, t_idle;
        do_txn(1'b1, 11'h2A0, 32'hCAFEF00D, 4'h3, 1, 0, 0, 32'h0BADC0DE, 2'b00, 10, 1'b1, t_rsp, t_idle);
        checks++;
        if (t_idle - t_rsp !== 11 || bus.cmd_valid !== 1'b1) begin
            failures++; $display("FAIL backpressure_hold got=%0d exp=11", t_idle - t_rsp);
        end
        do_txn(1'b0, ~11'h2A0, 32'hCAFEF00D, 4'h3, 0, 2, 0, 32'h0, 2'b11, 0, 1'b0, t_rsp, t_idle);
    endtask

    task automatic test_back_to_back;
        int t_rsp, t_idle;
        for (int i = 0; i < 3; i++) begin
            do_txn(1'(i), 11'($urandom), $urandom, 4'($urandom), 0, 0, 0, $urandom, 2'b00, 0, 1'b0, t_rsp, t_idle);
            checks++;
            if (t_idle !== 4) begin failures++; $display("FAIL back_to_back i=%0d got=%0d exp=4", i, t_idle); end
        end
    endtask

    task automatic test_random;
        int t_rsp, t_idle;
        for (int i = 0; i < 40; i++)
            do_txn(1'($urandom), 11'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom, 2'($urandom), $urandom_range(0, 3), 1'b0, t_rsp, t_idle);
    endtask

    task automatic test_async_reset;
        int t_rsp, t_idle;
        logic seen;
        bus.cmd_valid = 1; bus.cmd_rnw = 0; bus.cmd_addr = 11'h7F0; bus.cmd_wdata = 32'h1; bus.cmd_wstrb = 4'h1;
        @(negedge clk);
        bus.cmd_valid = 0; bus.awready = 1; bus.wready = 1;
        @(negedge clk);
        bus.awready = 0; bus.wready = 0;
        checks++;
        if ({bus.bready, bus.busy} !== 2'b11) begin failures++; $display("FAIL in_wr_b got=%b exp=11", {bus.bready, bus.busy}); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({bus.bready, bus.rsp_valid, bus.busy, bus.cmd_ready, bus.awvalid, bus.wvalid, bus.awaddr} !== '0) begin
            failures++; $display("FAIL async_reset got=%h exp=0", {bus.bready, bus.rsp_valid, bus.busy, bus.cmd_ready, bus.awvalid, bus.wvalid, bus.awaddr});
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.busy} !== 2'b10) begin failures++; $display("FAIL post_reset_ready got=%b exp=10", {bus.cmd_ready, bus.busy}); end
        seen = 0;
        repeat (5) begin bus.bvalid = 1; seen = seen | bus.rsp_valid | bus.bready; @(negedge clk); end
        bus.bvalid = 0;
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abandoned_rsp got=%b exp=0", seen); end
        do_txn(1'b1, 11'h0FF, 32'h0, 4'h0, 2, 0, 2, 32'hFEEDFACE, 2'b01, 1, 1'b0, t_rsp, t_idle);
    endtask

`ifdef AXI_CMD_TIMEOUT_EN
    task automatic test_timeout;
        int k;
        k = 0;
        bus.cmd_valid = 1; bus.cmd_rnw = 1; bus.cmd_addr = 11'h03C; bus.arready = 0;
        @(negedge clk);
        bus.cmd_valid = 0;
        while (bus.arvalid === 1'b1 && k < 100) begin k++; @(negedge clk); end
        checks++;
        if (k !== TO) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", k, TO); end
        checks++;
        if ({bus.rsp_valid, bus.rsp_rnw, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, bus.rready} !== {2'b11, 32'h0, 2'b11, 2'b10}) begin
            failures++; $display("FAIL timeout_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_rnw, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, bus.rready}, {2'b11, 32'h0, 2'b11, 2'b10});
        end
        bus.rsp_ready = 1;
        @(negedge clk);
        bus.rsp_ready = 0;
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin failures++; $display("FAIL timeout_recover got=%b exp=10", {bus.cmd_ready, bus.rsp_valid}); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_zero_wait();
        test_write_w_first();
        test_read_wait();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_async_reset();
`ifdef AXI_CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
